// File: rtl/divmod_arbiter_pkg.sv
// divmod_arbiter_pkg
//   Shared types and helpers for the divmod arbiter.
//   - state_e  : arbiter FSM state encoding (3 bits)
//   - wrap_inc : increment an index modulo n with an explicit wrap, no overflow reliance
package divmod_arbiter_pkg;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StIssueDly = 3'd1,
        StWait     = 3'd2,
        StResp     = 3'd3
    } state_e;

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/divmod_arbiter_rr_pick.sv
// divmod_arbiter_rr_pick
//   Combinational circular priority encoder: returns the first set request at or after ptr_i,
//   wrapping past N-1 back to 0.
//   Ports:
//     req_i  [N-1:0]     request vector
//     ptr_i  [IdxW-1:0]  search start index (must be < N)
//     idx_o  [IdxW-1:0]  index of the chosen request (0 when none)
//     any_o              at least one request set
module divmod_arbiter_rr_pick #(
    parameter int unsigned N    = 3,
    parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic [IdxW-1:0] idx_o,
    output logic            any_o
);

    int unsigned cand;

    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        cand  = 0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = 32'(ptr_i) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!any_o && req_i[IdxW'(cand)]) begin
                any_o = 1'b1;
                idx_o = IdxW'(cand);
            end
        end
    end

endmodule

// File: rtl/divmod_arbiter.sv
// divmod_arbiter
//   Round-robin arbiter sharing one external divmod unit between NREQ requesters. Captures the
//   owner's operands, pulses dm_go, waits for ready/error (with a watchdog) and routes the
//   remainder back to the owner.
//   Ports:
//     clk, rst               clock; synchronous active-high reset
//     req [NREQ]             level request per requester
//     req_a, req_b           packed operands, requester i at [i*WIDTH +: WIDTH]
//     ack [NREQ]             one-cycle pulse: operands of requester i captured
//     resp_valid [NREQ]      one-cycle pulse: result for requester i on resp_mod/resp_error
//     resp_mod, resp_error   result (mod is 0 on error)
//     busy                   operation in flight
//     dm_go, dm_a, dm_b      divmod issue (operands held from issue to response)
//     dm_ready, dm_error, dm_mod  divmod completion
module divmod_arbiter
    import divmod_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH_LOG = 4,
    parameter int unsigned NREQ      = 3,
    parameter int unsigned TIMEOUT   = 64,
    parameter int unsigned WIDTH     = 1 << WIDTH_LOG
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       ack,
    output logic [NREQ-1:0]       resp_valid,
    output logic [WIDTH-1:0]      resp_mod,
    output logic                  resp_error,
    output logic                  busy,
    output logic                  dm_go,
    output logic [WIDTH-1:0]      dm_a,
    output logic [WIDTH-1:0]      dm_b,
    input  logic                  dm_ready,
    input  logic                  dm_error,
    input  logic [WIDTH-1:0]      dm_mod
);

    localparam int unsigned PtrW = $clog2(NREQ);
    localparam int unsigned WdW  = $clog2(TIMEOUT);

    state_e            state_q, state_d;
    logic [PtrW-1:0]   owner_q, owner_d;
    logic [PtrW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [WdW-1:0]    wdog_q, wdog_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic [NREQ-1:0]   resp_valid_q, resp_valid_d;
    logic [WIDTH-1:0]  resp_mod_q, resp_mod_d;
    logic              resp_error_q, resp_error_d;
    logic              dm_go_q, dm_go_d;
    logic [WIDTH-1:0]  dm_a_q, dm_a_d;
    logic [WIDTH-1:0]  dm_b_q, dm_b_d;

    logic [PtrW-1:0]   pick_idx;
    logic              pick_any;

    divmod_arbiter_rr_pick #(
        .N    (NREQ),
        .IdxW (PtrW)
    ) u_rr_pick (
        .req_i (req),
        .ptr_i (rr_ptr_q),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        rr_ptr_d     = rr_ptr_q;
        wdog_d       = wdog_q;
        ack_d        = '0;
        resp_valid_d = '0;
        resp_mod_d   = '0;
        resp_error_d = 1'b0;
        dm_go_d      = 1'b0;
        dm_a_d       = dm_a_q;
        dm_b_d       = dm_b_q;

        unique case (state_q)
            StIdle: begin
                if (pick_any) begin
                    owner_d           = pick_idx;
                    ack_d[pick_idx]   = 1'b1;
                    dm_go_d           = 1'b1;
                    dm_a_d            = req_a[32'(pick_idx) * WIDTH +: WIDTH];
                    dm_b_d            = req_b[32'(pick_idx) * WIDTH +: WIDTH];
                    state_d           = StIssueDly;
                end
            end
            // Gives the divmod one cycle to drop ready before it is sampled.
            StIssueDly: begin
                wdog_d  = '0;
                state_d = StWait;
            end
            StWait: begin
                if (dm_error) begin
                    resp_valid_d[owner_q] = 1'b1;
                    resp_error_d          = 1'b1;
                    state_d               = StResp;
                end else if (dm_ready) begin
                    resp_valid_d[owner_q] = 1'b1;
                    resp_mod_d            = dm_mod;
                    state_d               = StResp;
                end else if (wdog_q == WdW'(TIMEOUT - 1)) begin
                    resp_valid_d[owner_q] = 1'b1;
                    resp_error_d          = 1'b1;
                    state_d               = StResp;
                end else begin
                    wdog_d = wdog_q + WdW'(1);
                end
            end
            StResp: begin
                rr_ptr_d = PtrW'(wrap_inc(32'(owner_q), NREQ));
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            owner_q      <= '0;
            rr_ptr_q     <= '0;
            wdog_q       <= '0;
            ack_q        <= '0;
            resp_valid_q <= '0;
            resp_mod_q   <= '0;
            resp_error_q <= 1'b0;
            dm_go_q      <= 1'b0;
            dm_a_q       <= '0;
            dm_b_q       <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            rr_ptr_q     <= rr_ptr_d;
            wdog_q       <= wdog_d;
            ack_q        <= ack_d;
            resp_valid_q <= resp_valid_d;
            resp_mod_q   <= resp_mod_d;
            resp_error_q <= resp_error_d;
            dm_go_q      <= dm_go_d;
            dm_a_q       <= dm_a_d;
            dm_b_q       <= dm_b_d;
        end
    end

    assign ack        = ack_q;
    assign resp_valid = resp_valid_q;
    assign resp_mod   = resp_mod_q;
    assign resp_error = resp_error_q;
    assign busy       = (state_q != StIdle);
    assign dm_go      = dm_go_q;
    assign dm_a       = dm_a_q;
    assign dm_b       = dm_b_q;

endmodule
